reg_bus_arbiter: RTL and testbench
==================================

Name:
reg_bus_arbiter

Overview:
Shares the datapath register bus between several requesters (load/store sequencer, pointcloud address generator, host-config port, ...). Each cycle it picks one requester round-robin and drives its data onto BusOut. It decodes that requester's target address and operation into one-hot LD/INC/CLR strobes for the bank of bus registers. All outputs are registered, so the bus and strobes are glitch-free toward the register bank.

Parameters:
WIDTH, 8, bus / register data width
NREQ, 4, number of requesters (2..8)
NREG, 8, number of bus registers addressed
AW, 3, address width per requester (2**AW >= NREG)
MAXLOCK, 8, max consecutive cycles one requester may hold the bus via lock

Ports:
Clk  in  1  system clock, rising edge
RSTn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester bus request
lock  in  NREQ  per-requester hold-bus request, honoured only while granted
op  in  2*NREQ  per-requester op: 00 load, 01 increment, 10 clear, 11 nop
addr  in  AW*NREQ  per-requester target register index
wdata  in  WIDTH*NREQ  per-requester load data
gnt  out  NREQ  one-hot grant, registered
BusOut  out  WIDTH  shared bus data to all registers
LD  out  NREG  one-hot load strobe
INC  out  NREG  one-hot increment strobe
CLR  out  NREG  one-hot synchronous-clear strobe
busy  out  1  any grant active this cycle
err  out  1  one-cycle pulse: granted addr >= NREG

Behaviour:
- Reset (RSTn low, async): gnt=0, BusOut=0, LD/INC/CLR=0, busy=0, err=0, rr pointer=0, lock counter=0, state=IDLE.
- Latency: req sampled at edge k; gnt, BusOut, strobes and err are valid during cycle k+1. At most one bit set across LD|INC|CLR per cycle.
- States: IDLE, GRANT, LOCKED.
- IDLE: no req -> outputs 0. Any req -> arbitrate -> GRANT.
- Arbitration: search starts at index ptr, wraps modulo NREQ; the first req wins.
  - On a new grant to winner w: ptr <= (w+1) mod NREQ.
- GRANT: re-arbitrate every cycle with the same rule.
  - If the granted requester has req&lock high at the edge, go to LOCKED, keep gnt, and set lockcnt=1.
- LOCKED: gnt held with no re-arbitration while the holder has req&lock high and lockcnt < MAXLOCK; lockcnt increments each held cycle.
  - Holder drops req or lock -> normal arbitration that edge; ptr is already past the holder.
  - lockcnt reaches MAXLOCK -> forced release. The holder is excluded from that arbitration. If no other req is pending, the holder is regranted in GRANT, not LOCKED. lockcnt is then cleared.
- Decode of the granted requester:
  - op 00 -> LD[addr]=1, BusOut=wdata.
  - op 01 -> INC[addr]=1.
  - op 10 -> CLR[addr]=1.
  - op 11 -> no strobe, grant still consumed.
  - BusOut holds its last value for ops other than load.
- addr >= NREG: no strobe, err=1 for that cycle, grant still consumed.
- Simultaneous req and lock from a non-granted requester: lock is ignored until that requester is granted.
- Reset mid-lock clears everything immediately. The first grant after reset goes to the lowest-index active req, since ptr=0.
- Grant is combinationally independent of outputs; all outputs come from flops.

Test Plan:
- Reset, then req=0001, op0=00, addr0=3, wdata0=8'hAA -> next cycle gnt=0001, LD=00001000, BusOut=AA, busy=1.
- req=1111 held 8 cycles, all op=01, addr_i=i -> gnt cycles 0001,0010,0100,1000,0001... and INC follows addr; no requester granted twice before the others.
- req=0011, requester 1 lock=1 from first grant -> gnt=0010 for exactly MAXLOCK=8 cycles, then gnt=0001 the next cycle.
- Requester 2 op=10, addr=5 -> CLR=00100000 only. op=11 -> all strobes 0, gnt=0100. addr=7 with NREG=6 -> err pulse, no strobe.
- Assert RSTn low asynchronously mid-LOCKED, between clock edges -> all outputs 0 immediately. After release, req=1010 -> gnt=0010 first.
- Random req/lock/op/addr for 1000 cycles -> gnt always one-hot or zero, at most one strobe set, lock never exceeds MAXLOCK cycles.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin register-bus arbiter with bounded lock and one-hot LD/INC/CLR decode
// Clk, RSTn            : rising-edge clock, asynchronous active-low reset
// req, lock            : per-requester bus request and hold-bus request
// op, addr, wdata      : per-requester op (00 ld, 01 inc, 10 clr, 11 nop), register index, load data
// gnt, busy            : registered one-hot grant and any-grant flag
// BusOut, LD, INC, CLR : registered bus data and one-hot register strobes
// err                  : one-cycle pulse when the granted address is out of range
module reg_bus_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int MAXLOCK = 8
) (
    input  logic                  Clk,
    input  logic                  RSTn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [2*NREQ-1:0]     op,
    input  logic [AW*NREQ-1:0]    addr,
    input  logic [WIDTH*NREQ-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      BusOut,
    output logic [NREG-1:0]       LD,
    output logic [NREG-1:0]       INC,
    output logic [NREG-1:0]       CLR,
    output logic                  busy,
    output logic                  err
);
    localparam int PW = $clog2(NREQ);
    localparam int LW = $clog2(MAXLOCK + 1);
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2;
    logic [1:0] st, st_n;
    logic [PW-1:0] ptr, ptr_n, hold_idx, win, sel;
    logic [LW-1:0] lockcnt, lockcnt_n;
    logic [NREQ-1:0] cand, gnt_n;
    logic hold_lock, hold, forced, found, valid, bad;
    logic [1:0] op_s;
    logic [AW-1:0] addr_s;
    logic [WIDTH-1:0] wd_s, bus_n;
    logic [NREG-1:0] onehot, ld_n, inc_n, clr_n;

    always_comb begin
        hold_idx = '0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) hold_idx = PW'(i);
    end

    assign hold_lock = |(gnt & req & lock);
    // lockcnt counts held cycles after the first, so one lock owns the bus for MAXLOCK cycles in total
    assign hold   = hold_lock && (st == GRANT || (st == LOCKED && int'(lockcnt) < MAXLOCK - 1));
    assign forced = hold_lock && !hold;
    assign cand   = forced ? (req & ~gnt) : req;

    // win defaults to the holder so a forced release with nobody else waiting regrants it
    always_comb begin
        found = 1'b0;
        win   = hold_idx;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && cand[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign valid     = hold || found || forced;
    assign sel       = hold ? hold_idx : win;
    assign st_n      = hold ? LOCKED : valid ? GRANT : IDLE;
    assign gnt_n     = hold ? gnt : valid ? NREQ'(1) << win : '0;
    assign ptr_n     = (valid && !hold) ? PW'((int'(win) + 1) % NREQ) : ptr;
    assign lockcnt_n = !hold ? '0 : (st == GRANT) ? LW'(1) : lockcnt + 1'b1;

    assign op_s   = op[2*int'(sel) +: 2];
    assign addr_s = addr[AW*int'(sel) +: AW];
    assign wd_s   = wdata[WIDTH*int'(sel) +: WIDTH];
    assign bad    = int'(addr_s) >= NREG;
    assign onehot = NREG'(1) << addr_s;
    assign ld_n   = (valid && !bad && op_s == 2'b00) ? onehot : '0;
    assign inc_n  = (valid && !bad && op_s == 2'b01) ? onehot : '0;
    assign clr_n  = (valid && !bad && op_s == 2'b10) ? onehot : '0;
    // the bus idles at zero and otherwise only changes on a valid load
    assign bus_n  = !valid ? '0 : (!bad && op_s == 2'b00) ? wd_s : BusOut;

    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            st      <= IDLE;
            ptr     <= '0;
            lockcnt <= '0;
            gnt     <= '0;
            BusOut  <= '0;
            LD      <= '0;
            INC     <= '0;
            CLR     <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            st      <= st_n;
            ptr     <= ptr_n;
            lockcnt <= lockcnt_n;
            gnt     <= gnt_n;
            BusOut  <= bus_n;
            LD      <= ld_n;
            INC     <= inc_n;
            CLR     <= clr_n;
            busy    <= valid;
            err     <= valid && bad;
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: scoreboard bench for reg_bus_arbiter against a behavioural grant/decode model
module tb_reg_bus_arbiter;
    localparam int WIDTH = 8, NREQ = 4, NREG = 6, AW = 3, MAXLOCK = 8;
    logic Clk = 1'b0, RSTn = 1'b0;
    logic [3:0] req = '0, lock = '0;
    logic [7:0] op = '0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0] gnt;
    logic [7:0] BusOut;
    logic [5:0] LD, INC, CLR;
    logic busy, err;
    typedef struct packed {
        logic [3:0] g;
        logic [7:0] b;
        logic [5:0] ld, inc, clr;
        logic bz, e;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;
    int m_cur = -1, m_held = 0, m_ptr = 0;
    logic [7:0] m_bus = '0;

    always #5 Clk = ~Clk;

    reg_bus_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .AW(AW), .MAXLOCK(MAXLOCK)) dut (
        .Clk(Clk), .RSTn(RSTn), .req(req), .lock(lock), .op(op), .addr(addr), .wdata(wdata),
        .gnt(gnt), .BusOut(BusOut), .LD(LD), .INC(INC), .CLR(CLR), .busy(busy), .err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = -1;
        m_held = 0;
        m_ptr = 0;
        m_bus = '0;
        q.delete();
    endtask

    function automatic int pick(input logic [3:0] c, input int from);
        for (int k = 0; k < NREQ; k++) if (c[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    // drive one cycle of inputs and queue the outputs the next edge must produce
    task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic [7:0] o,
                         input logic [11:0] a, input logic [31:0] w);
        exp_t e;
        int nxt, ea;
        logic wants, bad;
        logic [3:0] c;
        logic [1:0] eo;
        @(negedge Clk);
        req = r; lock = l; op = o; addr = a; wdata = w;
        wants = (m_cur >= 0) ? (r[m_cur] & l[m_cur]) : 1'b0;
        if (wants && m_held < MAXLOCK) begin
            nxt = m_cur;
            m_held++;
        end else begin
            c = r;
            if (wants) c[m_cur] = 1'b0;
            nxt = pick(c, m_ptr);
            if (nxt < 0 && wants) nxt = m_cur;
            if (nxt >= 0) begin
                m_held = 1;
                m_ptr = (nxt + 1) % NREQ;
            end
        end
        m_cur = nxt;
        e = '0;
        if (nxt < 0) m_bus = '0;
        else begin
            eo = o[2*nxt +: 2];
            ea = int'(a[3*nxt +: 3]);
            bad = ea >= NREG;
            e.g = 4'b1 << nxt;
            e.bz = 1'b1;
            e.e = bad;
            e.ld = (!bad && eo == 2'd0) ? 6'b1 << ea : 6'b0;
            e.inc = (!bad && eo == 2'd1) ? 6'b1 << ea : 6'b0;
            e.clr = (!bad && eo == 2'd2) ? 6'b1 << ea : 6'b0;
            if (!bad && eo == 2'd0) m_bus = w[8*nxt +: 8];
        end
        e.b = m_bus;
        q.push_back(e);
    endtask

    task automatic obs();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (RSTn && q.size() > 0) begin
                e = q.pop_front();
                check("outputs", {gnt, BusOut, LD, INC, CLR, busy, err}, e);
                check("gnt_onehot0", 64'($onehot0(gnt)), 1);
                check("one_strobe", 64'($countones({LD, INC, CLR}) <= 1), 1);
            end
        end
    end

    initial begin
        int cnt[4];
        logic [3:0] g[14];
        logic [3:0] r, l;
        int f, run;
        model_reset();
        @(posedge Clk);
        #1;
        check("reset_outputs", {gnt, BusOut, LD, INC, CLR, busy, err}, 0);
        @(negedge Clk) RSTn = 1'b1;

        cycle(4'b0001, 4'b0000, 8'hFC, 12'd3, 32'h0000_00AA);
        obs();
        check("first_gnt", gnt, 4'b0001);
        check("first_ld", LD, 6'b001000);
        check("first_bus", BusOut, 8'hAA);
        check("first_busy", busy, 1);

        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(4'hF, 4'h0, 8'h55, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h0);
            obs();
            for (int i = 0; i < 4; i++) if (gnt[i]) cnt[i]++;
            if (k == 3) for (int i = 0; i < 4; i++) check("rr_first_round", cnt[i], 1);
        end
        for (int i = 0; i < 4; i++) check("rr_two_rounds", cnt[i], 2);

        cycle(4'h0, 4'h0, 8'hFF, 12'h0, 32'h0);
        obs();
        check("idle_gnt", {gnt, busy}, 0);

        for (int k = 0; k < 14; k++) begin
            cycle(4'b0011, 4'b0010, 8'hF7, {3'd0, 3'd0, 3'd4, 3'd0}, 32'h0);
            obs();
            g[k] = gnt;
        end
        f = 0;
        while (f < 14 && g[f] != 4'b0010) f++;
        run = 0;
        while (f + run < 14 && g[f + run] == 4'b0010) run++;
        check("lock_run", run, MAXLOCK);
        check("lock_release", (f + run < 14) ? g[f + run] : 4'hx, 4'b0001);
        cycle(4'h0, 4'h0, 8'hFF, 12'h0, 32'h0);

        cycle(4'b0100, 4'h0, 8'hEF, 12'h140, 32'h0);
        obs();
        check("clr_strobe", {LD, INC, CLR}, {6'b0, 6'b0, 6'b100000});
        check("clr_gnt", {gnt, err}, {4'b0100, 1'b0});
        cycle(4'b0100, 4'h0, 8'hFF, 12'h140, 32'h0);
        obs();
        check("nop_strobe", {LD, INC, CLR}, 0);
        check("nop_gnt", gnt, 4'b0100);
        cycle(4'b0100, 4'h0, 8'hEF, 12'h1C0, 32'h0);
        obs();
        check("bad_addr_err", err, 1);
        check("bad_addr_strobe", {LD, INC, CLR}, 0);
        cycle(4'h0, 4'h0, 8'hFF, 12'h0, 32'h0);
        obs();
        check("err_pulse_end", err, 0);

        for (int k = 0; k < 4; k++) cycle(4'b0011, 4'b0010, 8'hFF, 12'h0, 32'h0);
        @(posedge Clk);
        #2;
        check("pre_reset_locked", gnt, 4'b0010);
        #1 RSTn = 1'b0;
        #1;
        check("async_reset", {gnt, BusOut, LD, INC, CLR, busy, err}, 0);
        req = '0; lock = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk) RSTn = 1'b1;
        cycle(4'b1010, 4'h0, 8'hFF, 12'h0, 32'h0);
        obs();
        check("post_reset_gnt", gnt, 4'b0010);

        r = 4'hF;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            l = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            cycle(r, l, 8'($urandom), 12'($urandom), $urandom);
        end
        repeat (3) @(posedge Clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
